// File: rtl/simple_out_capture.sv
// Deserializes the core's 1-bit out stream LSB-first into WORD_W-bit words and buffers them in a small FIFO.
// Optional toggle counter is built when SIMPLE_OUT_CAPTURE_TOGGLE_CNT_EN is defined.
module simple_out_capture #(
    parameter int WORD_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int LVL_W     = PTR_W + 1,
    localparam int BIT_W     = $clog2(WORD_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              din,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [LVL_W-1:0]  level,
    output logic              overflow,
    input  logic              clr_ovf,
    output logic [CNT_W-1:0]  toggle_cnt
);

    logic [BIT_W-1:0]  bit_cnt;
    logic [WORD_W-2:0] shreg;
    logic [WORD_W-1:0] full_word;
    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              last_bit;
    logic              fifo_full;
    logic              pop;
    logic              wr_en;
    logic              drop;

    // Handshake: a word transfers on any rising edge where word_valid and word_ready are both 1;
    // word_valid never depends on word_ready, and word_data holds steady until that edge.
    assign word_valid = (level != '0);
    assign word_data  = word_valid ? mem[rd_ptr] : '0;
    assign fifo_full  = (level == LVL_W'(FIFO_DEPTH));
    assign last_bit   = en && (bit_cnt == BIT_W'(WORD_W - 1));
    assign full_word  = {din, shreg};
    assign pop        = word_valid && word_ready;
    // A simultaneous pop frees the slot, so a completing word is kept even when full.
    assign wr_en      = last_bit && (!fifo_full || pop);
    assign drop       = last_bit && fifo_full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (en) begin
            if (last_bit) begin
                bit_cnt <= '0;
                shreg   <= '0;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
                for (int i = 0; i < WORD_W - 1; i++) begin
                    if (bit_cnt == BIT_W'(i)) shreg[i] <= din;
                end
            end
        end
    end

    // Storage carries no reset; level gates visibility, so stale entries never reach word_data.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= full_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       overflow <= 1'b0;
        else if (drop)    overflow <= 1'b1;
        else if (clr_ovf) overflow <= 1'b0;
    end

`ifdef SIMPLE_OUT_CAPTURE_TOGGLE_CNT_EN
    logic prev_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_bit   <= 1'b0;
            toggle_cnt <= '0;
        end else if (en) begin
            prev_bit <= din;
            if ((din != prev_bit) && (toggle_cnt != {CNT_W{1'b1}}))
                toggle_cnt <= toggle_cnt + 1'b1;
        end
    end
`else
    assign toggle_cnt = '0;
`endif

endmodule

// File: tb/tb_simple_out_capture.sv
// Scoreboard bench for simple_out_capture: a reference FIFO model is updated as stimulus is driven
// and its head is compared against the DUT whenever a word is handed off.
module tb_simple_out_capture;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = 4;
  localparam int LW = $clog2(D) + 1;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          din;
  logic [W-1:0]  word_data;
  logic          word_valid;
  logic          word_ready;
  logic [LW-1:0] level;
  logic          overflow;
  logic          clr_ovf;
  logic [CW-1:0] toggle_cnt;

  simple_out_capture #(.WORD_W(W), .FIFO_DEPTH(D), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .din        (din),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .level      (level),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf),
    .toggle_cnt (toggle_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_word;
  int           m_cnt;
  logic         m_ovf;
  logic         m_prev;
  int           m_tog;
  int           n_chk;
  int           n_pass;
  logic [W-1:0] w [8];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_word = '0;
    m_cnt  = 0;
    m_ovf  = 1'b0;
    m_prev = 1'b0;
    m_tog  = 0;
  endtask

  task automatic check_outs();
    chk("level", 32'(level), 32'(exp_q.size()));
    chk("valid", 32'(word_valid), 32'(exp_q.size() > 0));
    chk("head", 32'(word_data), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'd0);
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("toggle", 32'(toggle_cnt), 32'(m_tog));
  endtask

  // driver: called at a falling edge; applies inputs, updates the model, checks after the rising edge
  task automatic step(input logic e, input logic d, input logic r, input logic c);
    int   sz0;
    logic pop_m;
    logic drop_m;
    en = e; din = d; word_ready = r; clr_ovf = c;
    #1;
    sz0    = exp_q.size();
    pop_m  = (sz0 > 0) && r;
    drop_m = 1'b0;
    if (pop_m) begin
      chk("pop_data", 32'(word_data), 32'(exp_q[0]));
      void'(exp_q.pop_front());
    end
    if (e) begin
      m_word[m_cnt] = d;
      if (m_cnt == W - 1) begin
        if (sz0 < D || pop_m) exp_q.push_back(m_word);
        else drop_m = 1'b1;
        m_word = '0;
        m_cnt  = 0;
      end else begin
        m_cnt++;
      end
`ifdef SIMPLE_OUT_CAPTURE_TOGGLE_CNT_EN
      if (d != m_prev && m_tog < (1 << CW) - 1) m_tog++;
`endif
      m_prev = d;
    end
    if (drop_m) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    @(posedge clk);
    #1;
    check_outs();
    @(negedge clk);
  endtask

  task automatic send_word(input logic [W-1:0] wd, input logic r_body, input logic r_last,
                           input logic c_last);
    for (int i = 0; i < W; i++)
      step(1'b1, wd[i], (i == W - 1) ? r_last : r_body, (i == W - 1) ? c_last : 1'b0);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0; en = 1'b0; din = 1'b0; word_ready = 1'b0; clr_ovf = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) w[i] = W'($urandom_range(0, 255));
    #12;
    check_outs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // basic word, LSB-first
    send_word(8'h0D, 1'b0, 1'b0, 1'b0);
    chk("word_0d", 32'(word_data), 32'h0D);
    chk("word_0d_level", 32'(level), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // stall after three bits
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (5) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("stall_word", 32'(word_data), 32'h0D);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // overflow: five words into four slots
    for (int i = 0; i < 5; i++) send_word(w[i], 1'b0, 1'b0, 1'b0);
    chk("ovf_level", 32'(level), 32'd4);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_head", 32'(word_data), 32'(w[0]));
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(overflow), 32'd0);

    // full FIFO, push and pop on the same edge
    send_word(w[5], 1'b0, 1'b1, 1'b0);
    chk("pp_level", 32'(level), 32'd4);
    chk("pp_ovf", 32'(overflow), 32'd0);

    // drop and clear on the same edge: set wins
    send_word(w[6], 1'b0, 1'b0, 1'b1);
    chk("set_wins", 32'(overflow), 32'd1);
    repeat (4) step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);

    // empty FIFO with ready high during the push
    send_word(w[7], 1'b1, 1'b1, 1'b0);
    chk("empty_push_level", 32'(level), 32'd1);
    chk("empty_push_head", 32'(word_data), 32'(w[7]));
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // random traffic
    repeat (400)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0));

    // async reset mid-word with data buffered
    send_word(8'hA5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outs();
    @(negedge clk);
    rst_n = 1'b1;

    // toggle activity: alternating stream starting at 1, also forms fresh words after reset
    for (int i = 0; i < 20; i++) step(1'b1, 1'(i % 2 == 0), 1'b0, 1'b0);
`ifdef SIMPLE_OUT_CAPTURE_TOGGLE_CNT_EN
    chk("toggle_sat", 32'(toggle_cnt), 32'd15);
`else
    chk("toggle_off", 32'(toggle_cnt), 32'd0);
`endif
    chk("fresh_word", 32'(word_data), 32'h55);
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
